// File: rtl/knn_ctrl.sv
// knn_ctrl: sequencer for the KNN sorted-list datapath.
// Fetches one distance per training point, inserts it into the list, then streams the K nearest ids.
module knn_ctrl #(
  parameter int DATA_W  = 32,
  parameter int NBR_KNN = 4,
  parameter int IDX_W   = 8,
  parameter int SEL_W   = $clog2(NBR_KNN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  npoints,
  output logic              busy,
  output logic              done,
  output logic              dist_req,
  output logic [IDX_W-1:0]  dist_id,
  input  logic              dist_ack,
  input  logic [DATA_W-1:0] dist_val,
  output logic              list_clr,
  output logic              list_valid,
  output logic [DATA_W-1:0] list_dist,
  output logic [IDX_W-1:0]  list_id,
  output logic [SEL_W-1:0]  knn_sel,
  input  logic [IDX_W-1:0]  knn_info,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_id,
  output logic [SEL_W-1:0]  res_rank
);

  // state  | meaning
  // IDLE   | waiting for start; also retires done/busy after a run
  // CLEAR  | list_clr pulse, point index reset
  // REQ    | dist_req held for point idx until dist_ack
  // INSERT | list_valid pulse, advance to next point or to readout
  // READ   | knn_sel = rank, list id captured at end of cycle
  // OUT    | result held until res_ready
  // DONE   | run finished, done pulses next cycle
  typedef enum logic [2:0] {IDLE, CLEAR, REQ, INSERT, READ, OUT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] count_m1;
  logic [SEL_W-1:0] rank;
  logic [SEL_W-1:0] last_rank;

  assign count_m1 = count - IDX_W'(1);

  // Only ranks that hold a real point are reported.
  always_comb begin
    if (count >= IDX_W'(NBR_KNN)) last_rank = SEL_W'(NBR_KNN - 1);
    else                          last_rank = count_m1[SEL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      rank       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dist_req   <= 1'b0;
      dist_id    <= '0;
      list_clr   <= 1'b0;
      list_valid <= 1'b0;
      list_dist  <= '0;
      list_id    <= '0;
      knn_sel    <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_rank   <= '0;
    end else if (abort && state != IDLE) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      dist_req   <= 1'b0;
      list_clr   <= 1'b0;
      list_valid <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !busy) begin
            busy <= 1'b1;
            if (npoints != '0) begin
              count    <= npoints;
              list_clr <= 1'b1;
              state    <= CLEAR;
            end else begin
              state <= DONE;
            end
          end
        end
        CLEAR: begin
          list_clr <= 1'b0;
          idx      <= '0;
          dist_id  <= '0;
          dist_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (dist_ack) begin
            dist_req   <= 1'b0;
            list_dist  <= dist_val;
            list_id    <= idx;
            list_valid <= 1'b1;
            state      <= INSERT;
          end
        end
        INSERT: begin
          list_valid <= 1'b0;
          if (idx == count_m1) begin
            rank    <= '0;
            knn_sel <= '0;
            state   <= READ;
          end else begin
            idx      <= idx + IDX_W'(1);
            dist_id  <= idx + IDX_W'(1);
            dist_req <= 1'b1;
            state    <= REQ;
          end
        end
        READ: begin
          res_id    <= knn_info;
          res_rank  <= rank;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (rank == last_rank) begin
              state <= DONE;
            end else begin
              rank    <= rank + SEL_W'(1);
              knn_sel <= rank + SEL_W'(1);
              state   <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_ctrl.sv
// Self-checking bench for knn_ctrl: randomized distance unit and host, sorted-list model,
// queue scoreboard fed by a nearest-first reference model.
module tb_knn_ctrl;
  localparam int DATA_W = 32;
  localparam int K      = 4;
  localparam int IDX_W  = 8;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [IDX_W-1:0]  npoints = '0;
  logic              busy, done, dist_req, list_clr, list_valid, res_valid;
  logic [IDX_W-1:0]  dist_id, list_id, res_id, knn_info;
  logic              dist_ack;
  logic [DATA_W-1:0] dist_val, list_dist;
  logic [SEL_W-1:0]  knn_sel, res_rank;
  logic              res_ready;

  always #5 clk = ~clk;

  knn_ctrl #(.DATA_W(DATA_W), .NBR_KNN(K), .IDX_W(IDX_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .npoints(npoints),
    .busy(busy), .done(done), .dist_req(dist_req), .dist_id(dist_id),
    .dist_ack(dist_ack), .dist_val(dist_val), .list_clr(list_clr),
    .list_valid(list_valid), .list_dist(list_dist), .list_id(list_id),
    .knn_sel(knn_sel), .knn_info(knn_info), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_rank(res_rank)
  );

  typedef struct packed { logic [DATA_W-1:0] d; logic [IDX_W-1:0] id; } ins_t;
  typedef struct packed { logic [IDX_W-1:0] id; logic [SEL_W-1:0] rank; } res_t;

  ins_t insq[$];
  res_t resq[$];

  logic [DATA_W-1:0] dist_mem [256];
  logic [DATA_W-1:0] lst_d [K];
  logic [IDX_W-1:0]  lst_i [K];
  assign knn_info = lst_i[knn_sel];

  int checks = 0, errors = 0;
  int done_cnt = 0, exp_done = 0, clr_cnt = 0, exp_clr = 0;
  int ack_max = 0, stall_max = 0;
  bit bp_on = 1'b0;
  logic [SEL_W-1:0] bp_rank = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Distance unit: acks each request after 0..ack_max cycles.
  initial begin
    int  wcnt;
    bit  inreq;
    wcnt = 0; inreq = 1'b0;
    dist_ack = 1'b0; dist_val = '0;
    forever begin
      @(posedge clk); #1;
      dist_ack = 1'b0;
      dist_val = $urandom;
      if (!dist_req) inreq = 1'b0;
      else if (!inreq) begin
        inreq = 1'b1;
        wcnt = $urandom_range(0, ack_max);
      end
      if (inreq) begin
        if (wcnt == 0) begin
          dist_ack = 1'b1;
          dist_val = dist_mem[dist_id];
          inreq = 1'b0;
        end else wcnt--;
      end
    end
  end

  // Host: accepts each result after 0..stall_max cycles (10 on the back-pressured rank).
  initial begin
    int scnt;
    bit inres;
    scnt = 0; inres = 1'b0;
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      res_ready = 1'b0;
      if (!res_valid) inres = 1'b0;
      else if (!inres) begin
        inres = 1'b1;
        scnt = (bp_on && res_rank == bp_rank) ? 10 : $urandom_range(0, stall_max);
      end
      if (inres) begin
        if (scnt == 0) begin
          res_ready = 1'b1;
          inres = 1'b0;
        end else scnt--;
      end
    end
  end

  // Monitor: protocol checks, scoreboard pops, and the sorted list the DUT reads back.
  initial begin
    logic p_req, p_ack, p_abort, p_rv, p_rr, p_clr, p_lv, p_done;
    logic [IDX_W-1:0] p_did, p_rid;
    logic [SEL_W-1:0] p_rrank;
    ins_t ei;
    res_t er;
    int   pos;
    {p_req, p_ack, p_abort, p_rv, p_rr, p_clr, p_lv, p_done} = '0;
    p_did = '0; p_rid = '0; p_rrank = '0;
    for (int i = 0; i < K; i++) begin lst_d[i] = '1; lst_i[i] = '0; end
    forever begin
      @(negedge clk);
      if (!rst) begin
        {p_req, p_ack, p_abort, p_rv, p_rr, p_clr, p_lv, p_done} = '0;
      end else begin
        if (p_req && !p_ack && !p_abort) begin
          chk("dist_req_held", 64'(dist_req), 1);
          chk("dist_id_stable", 64'(dist_id), 64'(p_did));
        end
        if (p_rv && !p_rr && !p_abort) begin
          chk("res_valid_held", 64'(res_valid), 1);
          chk("res_id_stable", 64'(res_id), 64'(p_rid));
          chk("res_rank_stable", 64'(res_rank), 64'(p_rrank));
        end
        if (p_clr || p_lv) chk("list_strobe_gap", 64'(list_valid), 0);
        if (p_clr) chk("list_clr_width", 64'(list_clr), 0);
        if (list_clr) begin
          clr_cnt++;
          for (int i = 0; i < K; i++) begin lst_d[i] = '1; lst_i[i] = '0; end
        end
        if (list_valid) begin
          chk("insert_expected", 64'(insq.size() != 0), 1);
          if (insq.size() != 0) begin
            ei = insq.pop_front();
            chk("list_dist", 64'(list_dist), 64'(ei.d));
            chk("list_id", 64'(list_id), 64'(ei.id));
          end
          pos = K;
          for (int i = K - 1; i >= 0; i--) if (lst_d[i] > list_dist) pos = i;
          if (pos < K) begin
            for (int i = K - 1; i > pos; i--) begin lst_d[i] = lst_d[i-1]; lst_i[i] = lst_i[i-1]; end
            lst_d[pos] = list_dist;
            lst_i[pos] = list_id;
          end
        end
        if (res_valid && res_ready) begin
          chk("result_expected", 64'(resq.size() != 0), 1);
          if (resq.size() != 0) begin
            er = resq.pop_front();
            chk("res_id", 64'(res_id), 64'(er.id));
            chk("res_rank", 64'(res_rank), 64'(er.rank));
          end
        end
        if (done) begin
          chk("done_expected", 64'(done_cnt < exp_done), 1);
          chk("done_after_results", 64'(resq.size()), 0);
          chk("busy_at_done", 64'(busy), 1);
          done_cnt++;
        end
        if (p_done) chk("busy_drop_after_done", 64'(busy), 0);
        p_req = dist_req; p_ack = dist_ack; p_abort = abort; p_did = dist_id;
        p_rv = res_valid; p_rr = res_ready; p_rid = res_id; p_rrank = res_rank;
        p_clr = list_clr; p_lv = list_valid; p_done = done;
      end
    end
  end

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) dist_mem[i] = $urandom;
  endtask

  // Reference: inserts in id order; results are the min(n,K) smallest distances, lower id on ties.
  task automatic launch(input int n, input bit expect_run, input int poke_after);
    bit used [256];
    int best;
    if (expect_run) begin
      for (int i = 0; i < 256; i++) used[i] = 1'b0;
      for (int i = 0; i < n; i++) insq.push_back('{d: dist_mem[i], id: IDX_W'(i)});
      for (int r = 0; r < n && r < K; r++) begin
        best = -1;
        for (int i = 0; i < n; i++)
          if (!used[i] && (best < 0 || dist_mem[i] < dist_mem[best])) best = i;
        used[best] = 1'b1;
        resq.push_back('{id: IDX_W'(best), rank: SEL_W'(r)});
      end
      exp_done++;
    end
    if (n != 0) exp_clr++;
    @(posedge clk); #1;
    start = 1'b1; npoints = IDX_W'(n);
    @(posedge clk); #1;
    start = 1'b0; npoints = IDX_W'($urandom);
    if (poke_after > 0) begin
      repeat (poke_after) @(posedge clk);
      #1; start = 1'b1; npoints = IDX_W'(n / 2 + 1);
      @(posedge clk); #1; start = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    int c;
    c = 0;
    while (done_cnt < exp_done && c < limit) begin @(negedge clk); c++; end
    chk({name, "_done_count"}, 64'(done_cnt), 64'(exp_done));
    chk({name, "_clr_count"}, 64'(clr_cnt), 64'(exp_clr));
    chk({name, "_inserts_drained"}, 64'(insq.size()), 0);
    chk({name, "_results_drained"}, 64'(resq.size()), 0);
    repeat (2) @(negedge clk);
    chk({name, "_idle_busy"}, 64'(busy), 0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 0);
    chk({name, "_done"}, 64'(done), 0);
    chk({name, "_dist_req"}, 64'(dist_req), 0);
    chk({name, "_list_clr"}, 64'(list_clr), 0);
    chk({name, "_list_valid"}, 64'(list_valid), 0);
    chk({name, "_res_valid"}, 64'(res_valid), 0);
    chk({name, "_dist_id"}, 64'(dist_id), 0);
    chk({name, "_list_dist"}, 64'(list_dist), 0);
    chk({name, "_list_id"}, 64'(list_id), 0);
    chk({name, "_knn_sel"}, 64'(knn_sel), 0);
    chk({name, "_res_id"}, 64'(res_id), 0);
    chk({name, "_res_rank"}, 64'(res_rank), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, done count %0d expected %0d", done_cnt, exp_done);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // npoints = 0: done two cycles after start, no list or result activity.
    launch(0, 1'b1, 0);
    @(negedge clk);
    chk("np0_busy_c1", 64'(busy), 1);
    chk("np0_done_c1", 64'(done), 0);
    @(negedge clk);
    chk("np0_done_c2", 64'(done), 1);
    @(negedge clk);
    chk("np0_done_c3", 64'(done), 0);
    chk("np0_busy_c3", 64'(busy), 0);
    wait_done("np0", 20);

    // Directed six-point run, immediate ack and ready: expect ids 3,1,5,4.
    dist_mem[0] = 50; dist_mem[1] = 10; dist_mem[2] = 40;
    dist_mem[3] = 5;  dist_mem[4] = 30; dist_mem[5] = 20;
    launch(6, 1'b1, 0);
    wait_done("np6", 200);

    fill_rand(2);
    launch(2, 1'b1, 0);
    wait_done("np2", 100);

    // Randomized runs with ack delays and host stalls; one gets a start while busy.
    ack_max = 7; stall_max = 5;
    for (int r = 0; r < 6; r++) begin
      n = (r == 2) ? 15 : $urandom_range(1, 20);
      fill_rand(n);
      launch(n, 1'b1, (r == 2) ? 6 : 0);
      wait_done("rand", n * 16 + 200);
    end

    // Back-pressure on the last result withholds done.
    bp_on = 1'b1; bp_rank = 2'd3;
    fill_rand(5);
    launch(5, 1'b1, 0);
    wait_done("backpressure", 300);
    bp_on = 1'b0;

    // Abort in the same cycle as the first dist_ack.
    ack_max = 0;
    fill_rand(5);
    launch(5, 1'b0, 0);
    c = 0;
    @(negedge clk);
    while (!dist_req && c < 50) begin @(negedge clk); c++; end
    chk("abort_saw_req", 64'(dist_req), 1);
    chk("abort_ack_same_cycle", 64'(dist_ack), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_dist_req", 64'(dist_req), 0);
    chk("abort_list_valid", 64'(list_valid), 0);
    chk("abort_done", 64'(done), 0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(exp_done));
    fill_rand(3);
    launch(3, 1'b1, 0);
    wait_done("after_abort", 100);

    // Longest run exercises the full-width index compare.
    ack_max = 3; stall_max = 2;
    fill_rand(255);
    launch(255, 1'b1, 0);
    wait_done("np255", 4000);

    // Asynchronous reset while a result is being presented.
    stall_max = 3;
    fill_rand(8);
    launch(8, 1'b1, 0);
    c = 0;
    while (!res_valid && c < 500) begin @(negedge clk); c++; end
    chk("rst_saw_res_valid", 64'(res_valid), 1);
    #2 rst = 1'b0;
    #1;
    check_zero("async_rst");
    insq.delete();
    resq.delete();
    exp_done = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fill_rand(1);
    launch(1, 1'b1, 0);
    wait_done("after_rst", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
